// File: rtl/tm1638_serial_xfer.sv
// ---------------------------------------------------------------------------
// tm1638_serial_xfer
//
// Purpose:
//   TM1638-style 3-wire serial master (STB / CLK / DIO), LSB first, one
//   command byte per transaction.  A write sends the command byte followed by
//   0..WR_BYTES data bytes.  A read sends the command byte, releases DIO for
//   RD_WAIT cycles, then shifts in RD_BYTES key bytes.  DIO is split into
//   out / oe / in so that the top level owns the tristate pad.
//
// Ports:
//   i_Clk, i_Rst       clock, synchronous active-high reset
//   i_Start            start request, accepted only while o_Busy = 0
//   i_Rd               1 = read transaction, 0 = write transaction
//   i_Cmd              command byte
//   i_Len              write data byte count (clamped to WR_BYTES)
//   i_Wr_Data          write bytes, byte k in [8k+7:8k], byte 0 sent first
//   o_Busy             transaction in progress
//   o_Done             one-cycle pulse at the end of every transaction
//   o_Rd_Valid         one-cycle pulse, o_Rd_Data updated (reads only)
//   o_Rd_Data          read bytes, byte k in [8k+7:8k], byte 0 received first
//   o_SPI_Stb          strobe, active low
//   o_SPI_Clk          serial clock, idles high
//   o_SPI_Dio_Out      DIO drive value
//   o_SPI_Dio_Oe       DIO output enable
//   i_SPI_Dio          DIO pad input
// ---------------------------------------------------------------------------
module tm1638_serial_xfer #(
  parameter int HALF_PERIOD = 5,
  parameter int WR_BYTES    = 16,
  parameter int RD_BYTES    = 4,
  parameter int RD_WAIT     = 25,
  parameter int STB_GAP     = 4,
  localparam int LEN_W      = $clog2(WR_BYTES + 1)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic                  i_Rd,
  input  logic [7:0]            i_Cmd,
  input  logic [LEN_W-1:0]      i_Len,
  input  logic [8*WR_BYTES-1:0] i_Wr_Data,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Rd_Valid,
  output logic [8*RD_BYTES-1:0] o_Rd_Data,
  output logic                  o_SPI_Stb,
  output logic                  o_SPI_Clk,
  output logic                  o_SPI_Dio_Out,
  output logic                  o_SPI_Dio_Oe,
  input  logic                  i_SPI_Dio
);

  localparam int TX_MAX_BITS = 8 * (1 + WR_BYTES);
  localparam int RX_BITS     = 8 * RD_BYTES;
  localparam int MAX_BITS    = (TX_MAX_BITS > RX_BITS) ? TX_MAX_BITS : RX_BITS;
  localparam int BIT_W       = $clog2(MAX_BITS + 1);
  localparam int PH_W        = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int WAIT_MAX    = (RD_WAIT > STB_GAP) ? RD_WAIT : STB_GAP;
  localparam int WAIT_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TX_LO   = 3'd1;
  localparam logic [2:0] S_TX_HI   = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RX_LO   = 3'd4;
  localparam logic [2:0] S_RX_HI   = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;

  logic [2:0]             state;
  logic [PH_W-1:0]        phase_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [BIT_W-1:0]       tx_bits;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   is_rd;
  logic [TX_MAX_BITS-1:0] tx_shift;
  logic [RX_BITS-1:0]     rx_shift;
  logic [LEN_W-1:0]       len_clamped;
  logic                   phase_last;

  assign phase_last = (phase_cnt == PH_W'(HALF_PERIOD - 1));
  assign o_Busy     = (state != S_IDLE);

  // Oversized write lengths are clamped so the bit counter never runs past
  // the loaded shift register.
  always_comb begin
    len_clamped = i_Len;
    if (i_Len > LEN_W'(WR_BYTES)) begin
      len_clamped = LEN_W'(WR_BYTES);
    end
  end

  // Main sequencer.  The command and write bytes are loaded into one shift
  // register, command in the low byte, so the serial stream is simply its
  // LSB shifted out one bit per SCLK period.  Received bits enter at the top
  // of rx_shift, so after RX_BITS shifts bit 0 holds the first received bit.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      bit_cnt    <= '0;
      tx_bits    <= '0;
      wait_cnt   <= '0;
      is_rd      <= 1'b0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      o_Done     <= 1'b0;
      o_Rd_Valid <= 1'b0;
      o_Rd_Data  <= '0;
    end else begin
      o_Done     <= 1'b0;
      o_Rd_Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Start) begin
            state     <= S_TX_LO;
            is_rd     <= i_Rd;
            tx_shift  <= {i_Wr_Data, i_Cmd};
            tx_bits   <= i_Rd ? BIT_W'(8) : BIT_W'((int'(len_clamped) + 1) * 8);
            phase_cnt <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
          end
        end
        S_TX_LO: begin
          if (phase_last) begin
            phase_cnt <= '0;
            state     <= S_TX_HI;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_TX_HI: begin
          if (phase_last) begin
            phase_cnt <= '0;
            tx_shift  <= tx_shift >> 1;
            if (bit_cnt == tx_bits - BIT_W'(1)) begin
              bit_cnt  <= '0;
              wait_cnt <= '0;
              state    <= is_rd ? S_RD_WAIT : S_GAP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= S_TX_LO;
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_RD_WAIT: begin
          if (wait_cnt == WAIT_W'(RD_WAIT - 1)) begin
            wait_cnt <= '0;
            state    <= S_RX_LO;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_RX_LO: begin
          if (phase_last) begin
            phase_cnt <= '0;
            state     <= S_RX_HI;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_RX_HI: begin
          if (phase_last) begin
            phase_cnt <= '0;
            rx_shift  <= {i_SPI_Dio, rx_shift[RX_BITS-1:1]};
            if (bit_cnt == BIT_W'(RX_BITS - 1)) begin
              bit_cnt  <= '0;
              wait_cnt <= '0;
              state    <= S_GAP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= S_RX_LO;
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        S_GAP: begin
          if (wait_cnt == WAIT_W'(STB_GAP - 1)) begin
            wait_cnt <= '0;
            state    <= S_IDLE;
            o_Done   <= 1'b1;
            if (is_rd) begin
              o_Rd_Valid <= 1'b1;
              o_Rd_Data  <= rx_shift;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Pin levels are a pure function of the registered state, so reset and
  // abort return every pin to its idle level on the very next cycle.
  always_comb begin
    o_SPI_Stb     = 1'b1;
    o_SPI_Clk     = 1'b1;
    o_SPI_Dio_Out = 1'b0;
    o_SPI_Dio_Oe  = 1'b0;
    case (state)
      S_TX_LO: begin
        o_SPI_Stb     = 1'b0;
        o_SPI_Clk     = 1'b0;
        o_SPI_Dio_Out = tx_shift[0];
        o_SPI_Dio_Oe  = 1'b1;
      end
      S_TX_HI: begin
        o_SPI_Stb     = 1'b0;
        o_SPI_Dio_Out = tx_shift[0];
        o_SPI_Dio_Oe  = 1'b1;
      end
      S_RD_WAIT: begin
        o_SPI_Stb = 1'b0;
      end
      S_RX_LO: begin
        o_SPI_Stb = 1'b0;
        o_SPI_Clk = 1'b0;
      end
      S_RX_HI: begin
        o_SPI_Stb = 1'b0;
      end
      default: begin
        o_SPI_Stb = 1'b1;
      end
    endcase
  end

endmodule
